// File: rtl/alu_sequencer_if.sv
// Bundles the instruction-memory port and the ALU operand/result port of alu_sequencer.
interface alu_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [6:0]  alu_instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_reg8;
  logic [15:0] alu_value;
  logic        alu_highlow;
  logic        alu_f1;
  logic        alu_f2;
  logic [31:0] alu_c;
  logic        alu_f3;
  logic        alu_addrch;
  logic [31:0] alu_naddr;

  modport master (
    output imem_req, imem_addr, alu_instr, alu_a, alu_b, alu_reg8,
           alu_value, alu_highlow, alu_f1, alu_f2,
    input  imem_ack, imem_rdata, alu_c, alu_f3, alu_addrch, alu_naddr
  );

  modport slave (
    input  imem_req, imem_addr, alu_instr, alu_a, alu_b, alu_reg8,
           alu_value, alu_highlow, alu_f1, alu_f2,
    output imem_ack, imem_rdata, alu_c, alu_f3, alu_addrch, alu_naddr
  );
endinterface

// File: rtl/alu_sequencer.sv
// Fetches and decodes instruction words, feeds the ALU from a 16x32 register file
// and 4-bit flag file, and writes results/branch targets back in a 4-cycle loop.
module alu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned LINK_REG = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   run,
  alu_sequencer_if.master        bus,
  output logic                   halted,
  output logic [31:0]            pc,
  input  logic [3:0]             dbg_sel,
  output logic [31:0]            dbg_data
);
  localparam int unsigned W = 32;
  localparam int unsigned NREG = 16;
  localparam logic [3:0]  LINK_IDX = 4'(LINK_REG);
  localparam logic [6:0]  OP_NOP = 7'd127;
  localparam logic [6:0]  OP_LOAD_A = 7'd5;
  localparam logic [6:0]  OP_LOAD_B = 7'd6;
  localparam logic [6:0]  OP_LAST_WR = 7'd7;
  localparam logic [6:0]  OP_LAST_FLAG = 7'd13;
  localparam logic [6:0]  OP_JUMP = 7'd14;
  localparam logic [6:0]  OP_BRANCH = 7'd15;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    pc_q, pc_d;
  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [3:0]      flags_q, flags_d;
  logic [6:0]      op_q, op_d;
  logic [3:0]      rd_q, rd_d;
  logic            req_q, req_d;
  logic [6:0]      instr_q, instr_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, r8_q, r8_d;
  logic [15:0]     value_q, value_d;
  logic            hl_q, hl_d, f1_q, f1_d, f2_q, f2_d;
  logic            halted_q, halted_d;

  logic [6:0] f_op;
  logic [3:0] f_rd, f_ra, f_rb;
  assign f_op = bus.imem_rdata[31:25];
  assign f_rd = bus.imem_rdata[24:21];
  assign f_ra = bus.imem_rdata[20:17];
  assign f_rb = bus.imem_rdata[16:13];

  // Next-state, datapath and output lookahead
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    regs_d  = regs_q;
    flags_d = flags_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    r8_d    = r8_q;
    value_d = value_q;
    hl_d    = hl_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    unique case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          // Operands are read here so they are already valid throughout DECODE
          op_d  = f_op;
          rd_d  = f_rd;
          a_d   = regs_q[f_ra];
          b_d   = regs_q[f_rb];
          r8_d  = regs_q[LINK_IDX];
          f1_d  = flags_q[f_ra[1:0]];
          f2_d  = flags_q[f_rb[1:0]];
          if (f_op == OP_LOAD_A || f_op == OP_LOAD_B) begin
            value_d = bus.imem_rdata[15:0];
            hl_d    = bus.imem_rdata[16];
          end else begin
            value_d = '0;
            hl_d    = 1'b0;
          end
          state_d = DECODE;
        end
      end
      DECODE: state_d = (op_q == OP_NOP) ? HALT : EXEC;
      EXEC:   state_d = WB;
      WB: begin
        if (op_q <= OP_LAST_WR)        regs_d[rd_q] = bus.alu_c;
        else if (op_q <= OP_LAST_FLAG) flags_d[rd_q[1:0]] = bus.alu_f3;
        pc_d = pc_q + 32'd1;
        // addrch is stale for every op except the two branch kinds
        if (op_q == OP_JUMP)                           pc_d = bus.alu_naddr;
        else if (op_q == OP_BRANCH && bus.alu_addrch)  pc_d = regs_q[LINK_IDX];
        state_d = run ? FETCH : IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    req_d    = (state_d == FETCH);
    instr_d  = (state_d == EXEC) ? op_q : OP_NOP;
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      regs_q   <= '{default: '0};
      flags_q  <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      req_q    <= 1'b0;
      instr_q  <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      r8_q     <= '0;
      value_q  <= '0;
      hl_q     <= 1'b0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      regs_q   <= regs_d;
      flags_q  <= flags_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      req_q    <= req_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r8_q     <= r8_d;
      value_q  <= value_d;
      hl_q     <= hl_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.alu_instr   = instr_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_reg8    = r8_q;
  assign bus.alu_value   = value_q;
  assign bus.alu_highlow = hl_q;
  assign bus.alu_f1      = f1_q;
  assign bus.alu_f2      = f2_q;
  assign halted          = halted_q;
  assign pc              = pc_q;
  assign dbg_data        = regs_q[dbg_sel];
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control end of the ALU interface. It fetches 32-bit instruction words over a request/acknowledge memory port and decodes them.
- It reads a 16x32 register file and a 4-bit flag file. It drives the ALU operand, opcode and flag inputs.
- After the ALU's registered result appears, it writes C or F3 back. It also applies the branch outputs (addrch/naddr) to the program counter.
- Sits between instruction memory and the ALU, on the same clock.

Parameters:
- RESET_PC, 32'h0000_0000: program counter value after reset.
- LINK_REG, 8: register index presented on alu_reg8 and used as the op-15 branch target.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- run  input  1  start/continue execution
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch word address (equals pc)
- imem_ack  input  1  fetch data valid
- imem_rdata  input  32  instruction word
- alu_instr  output  7  ALU opcode
- alu_a  output  32  operand A = regs[ra]
- alu_b  output  32  operand B = regs[rb]
- alu_reg8  output  32  regs[LINK_REG]
- alu_value  output  16  immediate
- alu_highlow  output  1  load half select
- alu_f1  output  1  flags[ra[1:0]]
- alu_f2  output  1  flags[rb[1:0]]
- alu_c  input  32  ALU result
- alu_f3  input  1  ALU flag result
- alu_addrch  input  1  ALU branch-taken
- alu_naddr  input  32  ALU branch target
- halted  output  1  HALT executed
- pc  output  32  current program counter
- dbg_sel  input  4  debug register select
- dbg_data  output  32  regs[dbg_sel], combinational

Behaviour:
- Instruction fields:
  - op = [31:25], rd = [24:21], ra = [20:17], rb = [16:13].
  - Ops 5/6 only: highlow = [16], value = [15:0].
  - All other ops: alu_value = 0 and alu_highlow = 0.
- Reset (async, while reset_n=0):
  - state = IDLE, pc = RESET_PC, regs = 0, flags = 0.
  - imem_req = 0, alu_instr = 7'd127, halted = 0.
  - All other outputs are 0.
  - Reset mid-fetch drops imem_req immediately. A late imem_ack is ignored.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: go to FETCH when run=1.
- FETCH:
  - imem_req=1 with imem_addr=pc, both held stable until imem_ack=1 is sampled.
  - On ack, latch imem_rdata into the instruction register, deassert req the next cycle and go to DECODE.
  - Wait states are unbounded.
- DECODE: drive alu_a, alu_b, alu_reg8, alu_value, alu_highlow, alu_f1 and alu_f2 from the registered fields; go to EXEC.
- EXEC:
  - alu_instr = op, for exactly one cycle. Operands are held stable.
  - In every other state alu_instr = 7'd127, which the ALU ignores.
  - Go to WB.
- WB (samples ALU outputs registered at the end of EXEC):
  - ops 0-7: regs[rd] <= alu_c.
  - ops 8-13: flags[rd[1:0]] <= alu_f3.
  - op 14: pc <= alu_naddr.
  - op 15: if alu_addrch then pc <= regs[LINK_REG], else pc <= pc+1.
  - alu_addrch is honoured only for ops 14/15; the ALU holds it stale otherwise.
  - ops 16-126: NOP.
  - All non-branch ops: pc <= pc+1 (wraps 32'hFFFF_FFFF -> 0).
  - Then go to FETCH if run=1, else IDLE.
- op 127 (HALT): DECODE goes directly to HALT with halted=1 and pc unchanged. HALT is left only by reset.
- Latency: 4 cycles per instruction with zero-wait ack (FETCH, DECODE, EXEC, WB).
- Register reads in DECODE see the previous WB's write; no bypass is needed.
- run=0 mid-instruction finishes the instruction and then idles.

Test Plan:
- Reset with run=1, ack always high, word 0 = ADD r1,r0,r0 (op 0) -> imem_req in first FETCH, addr 0; regs[1]=0; pc=1 after 4 cycles.
- Program LOAD r2 (op5) value 16'h1234, highlow=0, then op5 highlow=1 value 16'hABCD, then ADD r3,r2,r2 -> dbg_data(r3) = 2*regs[2] as produced by the ALU; pc=3.
- op 8 with regs[4]=regs[5]=7, rd=1 -> flags[1]=1; then op15 with ra=1 and regs[8]=32'h40 -> next imem_addr=32'h40.
- op 15 with a clear flag after an earlier op 14 (ALU addrch sticky) -> pc=pc+1, no branch taken.
- imem_ack delayed 5 cycles -> imem_req and imem_addr stable throughout, alu_instr=127 until EXEC; then assert reset_n=0 during a second FETCH -> imem_req=0 at once, pc=RESET_PC.
- op 127 -> halted=1, imem_req never reasserts for 20 cycles, regs unchanged.
